// File: rtl/rr_arbiter6_if.sv
// Bundle of requester lanes, grant outputs and transfer handshake for the
// six-way round-robin arbiter. The producer side of req/lanes is the master;
// the arbiter itself is the slave.
interface rr_arbiter6_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] i_0;
  logic [WIDTH-1:0] i_1;
  logic [WIDTH-1:0] i_2;
  logic [WIDTH-1:0] i_3;
  logic [WIDTH-1:0] i_4;
  logic [WIDTH-1:0] i_5;
  logic [5:0]       req;
  logic             out_ready;
  logic [5:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic [5:0]       ack;
  logic [7:0]       xfer_cnt;

  modport master (
    output i_0, i_1, i_2, i_3, i_4, i_5, req, out_ready,
    input  sel, out_data, out_valid, ack, xfer_cnt
  );

  modport slave (
    input  i_0, i_1, i_2, i_3, i_4, i_5, req, out_ready,
    output sel, out_data, out_valid, ack, xfer_cnt
  );
endinterface

// File: rtl/rr_arbiter6.sv
// Six-lane round-robin arbiter with a registered output lane. One transfer is
// pending at a time; on completion the next winner is chosen in the same edge
// so a continuously requesting set of lanes sees no idle bubble.
module rr_arbiter6 #(
  parameter int WIDTH = 3
) (
  input logic          clk,
  input logic          rst_n,
  rr_arbiter6_if.slave bus
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       sel_q, sel_d;
  logic [5:0]       ack_q, ack_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [2:0]       last_q, last_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] lane [6];

  assign lane[0] = bus.i_0;
  assign lane[1] = bus.i_1;
  assign lane[2] = bus.i_2;
  assign lane[3] = bus.i_3;
  assign lane[4] = bus.i_4;
  assign lane[5] = bus.i_5;

  // First set request bit strictly after from_idx, wrapping 5->0. The scan
  // ends on from_idx itself, so a lone requester that just completed wins
  // again. Only meaningful when req is non-zero.
  function automatic logic [2:0] pick(input logic [5:0] r, input logic [2:0] from_idx);
    logic [2:0] idx;
    logic       found;
    pick  = from_idx;
    found = 1'b0;
    idx   = from_idx;
    for (int off = 0; off < 6; off++) begin
      idx = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Next-state and output-register computation for the IDLE/BUSY machine.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned,
    // which is what keeps this block from inferring latches.
    state_d = state_q;
    sel_d   = sel_q;
    ack_d   = '0;
    data_d  = data_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = pick(bus.req, last_q);
          sel_d   = 6'b000001 << gnt_d;
          data_d  = lane[gnt_d];
          state_d = BUSY;
        end else begin
          sel_d = '0;
        end
      end
      BUSY: begin
        // Requests seen here are only acted upon at completion: no preemption.
        if (bus.out_ready) begin
          ack_d  = sel_q;
          last_d = gnt_q;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
          if (|bus.req) begin
            gnt_d  = pick(bus.req, gnt_q);
            sel_d  = 6'b000001 << gnt_d;
            data_d = lane[gnt_d];
          end else begin
            sel_d   = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
      end
    endcase
  end

  // State and output registers; reset leaves lane 0 with first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every flop samples the values
    // from before this edge, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      ack_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 3'd5;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.ack       = ack_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == BUSY);
  assign bus.xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_arbiter6.sv
// Self-checking bench for rr_arbiter6: a directed vector table, hand-written
// multi-cycle sequences and randomized traffic, all compared against a
// transaction-level model of the arbitration rules.
module tb_rr_arbiter6;
  localparam int W = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter6_if #(.WIDTH(W)) bus ();
  rr_arbiter6 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which lane holds the pending transfer (if any), who was
  // served last, the captured data, the ack pulse and the transfer count.
  bit           m_busy;
  int           m_gnt;
  int           m_last;
  logic [W-1:0] m_data;
  logic [5:0]   m_ack;
  int           m_cnt;

  typedef struct {
    logic [5:0]   req;
    logic         rdy;
    logic [5:0]   sel;
    logic [W-1:0] data;
    logic         valid;
    logic [5:0]   ack;
    logic [7:0]   cnt;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] m_lane(input int k);
    case (k)
      0:       return bus.i_0;
      1:       return bus.i_1;
      2:       return bus.i_2;
      3:       return bus.i_3;
      4:       return bus.i_4;
      default: return bus.i_5;
    endcase
  endfunction

  function automatic int m_pick(input logic [5:0] r, input int last);
    for (int k = 1; k <= 6; k++)
      if (r[(last + k) % 6]) return (last + k) % 6;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_last = 5; m_data = '0; m_ack = '0; m_cnt = 0;
  endtask

  task automatic model_update();
    logic [5:0] r;
    r     = bus.req;
    m_ack = '0;
    if (!m_busy) begin
      if (r != 0) begin
        m_gnt  = m_pick(r, m_last);
        m_data = m_lane(m_gnt);
        m_busy = 1;
      end
    end else if (bus.out_ready) begin
      m_ack[m_gnt] = 1'b1;
      m_last = m_gnt;
      if (m_cnt < 255) m_cnt++;
      if (r != 0) begin
        m_gnt  = m_pick(r, m_last);
        m_data = m_lane(m_gnt);
      end else begin
        m_busy = 0;
      end
    end
  endtask

  task automatic check_model();
    check("model_sel",   bus.sel,       m_busy ? (32'd1 << m_gnt) : 32'd0);
    check("model_data",  bus.out_data,  m_data);
    check("model_valid", bus.out_valid, m_busy);
    check("model_ack",   bus.ack,       m_ack);
    check("model_cnt",   bus.xfer_cnt,  m_cnt);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
  endtask

  task automatic drive(input logic [5:0] r, input logic rdy);
    bus.req       = r;
    bus.out_ready = rdy;
  endtask

  task automatic set_lanes(input logic [W-1:0] a, b, c, d, e, f);
    bus.i_0 = a; bus.i_1 = b; bus.i_2 = c; bus.i_3 = d; bus.i_4 = e; bus.i_5 = f;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_sel",   bus.sel,       0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data",  bus.out_data,  0);
    check("rst_ack",   bus.ack,       0);
    check("rst_cnt",   bus.xfer_cnt,  0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Grant and ack vectors must be zero or one-hot on every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("sel_onehot0", $onehot0(bus.sel), 1);
      check("ack_onehot0", $onehot0(bus.ack), 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drive(6'b0, 1'b0);
    set_lanes(3'd3, 3'd1, 3'd5, 3'd2, 3'd7, 3'd6);
    model_reset();

    // Directed table: lanes fixed at i_0..i_5 = 3,1,5,2,7,6, starting from reset.
    //            req        rdy   sel        data  valid ack        cnt
    tbl[0]  = '{6'b100001, 1'b1, 6'b000001, 3'd3, 1'b1, 6'b000000, 8'd0};
    tbl[1]  = '{6'b100001, 1'b1, 6'b100000, 3'd6, 1'b1, 6'b000001, 8'd1};
    tbl[2]  = '{6'b000000, 1'b1, 6'b000000, 3'd6, 1'b0, 6'b100000, 8'd2};
    tbl[3]  = '{6'b000000, 1'b0, 6'b000000, 3'd6, 1'b0, 6'b000000, 8'd2};
    tbl[4]  = '{6'b011000, 1'b0, 6'b001000, 3'd2, 1'b1, 6'b000000, 8'd2};
    tbl[5]  = '{6'b011000, 1'b0, 6'b001000, 3'd2, 1'b1, 6'b000000, 8'd2};
    tbl[6]  = '{6'b000000, 1'b1, 6'b000000, 3'd2, 1'b0, 6'b001000, 8'd3};
    tbl[7]  = '{6'b010000, 1'b1, 6'b010000, 3'd7, 1'b1, 6'b000000, 8'd3};
    tbl[8]  = '{6'b010000, 1'b1, 6'b010000, 3'd7, 1'b1, 6'b010000, 8'd4};
    tbl[9]  = '{6'b010001, 1'b1, 6'b000001, 3'd3, 1'b1, 6'b010000, 8'd5};
    tbl[10] = '{6'b000110, 1'b1, 6'b000010, 3'd1, 1'b1, 6'b000001, 8'd6};
    tbl[11] = '{6'b000000, 1'b1, 6'b000000, 3'd1, 1'b0, 6'b000010, 8'd7};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].req, tbl[i].rdy);
      cycle();
      check($sformatf("tbl%0d_sel", i),   bus.sel,       tbl[i].sel);
      check($sformatf("tbl%0d_data", i),  bus.out_data,  tbl[i].data);
      check($sformatf("tbl%0d_valid", i), bus.out_valid, tbl[i].valid);
      check($sformatf("tbl%0d_ack", i),   bus.ack,       tbl[i].ack);
      check($sformatf("tbl%0d_cnt", i),   bus.xfer_cnt,  tbl[i].cnt);
    end

    // All lanes requesting with a ready consumer: grant rotates every cycle.
    do_reset();
    drive(6'b111111, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      cycle();
      if (k <= 12) check("rot_sel", bus.sel, 32'd1 << ((k - 1) % 6));
    end
    check("rot_cnt12", bus.xfer_cnt, 12);

    // Keep going far past 255 completions: the counter must saturate.
    for (int k = 0; k < 300; k++) cycle();
    check("sat_cnt", bus.xfer_cnt, 255);
    cycle();
    check("sat_hold", bus.xfer_cnt, 255);

    // Stalled transfer on lane 2: data and grant hold while the lane changes
    // and its request drops; one ack once the consumer accepts.
    do_reset();
    set_lanes(3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0);
    drive(6'b000100, 1'b0);
    cycle();
    bus.i_2 = 3'd1;
    drive(6'b000000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("stall_sel",   bus.sel,       6'b000100);
      check("stall_data",  bus.out_data,  5);
      check("stall_valid", bus.out_valid, 1);
      check("stall_ack",   bus.ack,       0);
    end
    drive(6'b000000, 1'b1);
    cycle();
    check("stall_ack_pulse", bus.ack, 6'b000100);
    cycle();
    check("stall_ack_once", bus.ack, 0);

    // Lone requester on lane 4: back-to-back regrants, valid never drops.
    do_reset();
    set_lanes(3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7);
    drive(6'b010000, 1'b1);
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      check("solo_sel",   bus.sel,       6'b010000);
      check("solo_valid", bus.out_valid, 1);
      check("solo_ack",   bus.ack,       6'b010000);
    end

    // Asynchronous reset in the middle of a pending transfer.
    do_reset();
    drive(6'b000011, 1'b1);
    cycle();
    cycle();
    drive(6'b000011, 1'b0);
    cycle();
    check("pre_rst_cnt", bus.xfer_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_sel",   bus.sel,       0);
    check("async_valid", bus.out_valid, 0);
    check("async_data",  bus.out_data,  0);
    check("async_ack",   bus.ack,       0);
    check("async_cnt",   bus.xfer_cnt,  0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(6'b110000, 1'b0);
    cycle();
    check("post_rst_grant", bus.sel, 6'b010000);
    check("post_rst_ack",   bus.ack, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      logic [5:0] r;
      r = 6'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      set_lanes(W'($urandom), W'($urandom), W'($urandom),
                W'($urandom), W'($urandom), W'($urandom));
      drive(r, $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
